// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges the PS/2 keyboard and MiSTer joysticks into active-low cabinet controls.
// Latency: joystick -> outputs 1 clk; ps2_key toggle -> latch 1 clk -> outputs 2 clk; all outputs registered.
// Backpressure: none; every input is a level (or toggle strobe) sampled on each clk_sys edge.
module arcade_input_mapper #(
  parameter int PLAYERS  = 2,
  parameter int BUTTONS  = 4,
  parameter int COIN_MIN = 2450000,
  parameter int AF_HALF  = 1633333
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [10:0]                ps2_key,
  input  logic [16*PLAYERS-1:0]      joystick,
  input  logic [1:0]                 socd_mode,
  input  logic [BUTTONS-1:0]         af_mask,
  output logic [4*PLAYERS-1:0]       dir_n,
  output logic [BUTTONS*PLAYERS-1:0] btn_n,
  output logic [PLAYERS-1:0]         start_n,
  output logic [PLAYERS-1:0]         coin_n,
  output logic                       service_n,
  output logic                       pause_btn
);

  localparam int CW = $clog2(COIN_MIN + 1);
  localparam int AW = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;

  // Keyboard key state. Directions and buttons only ever belong to P1.
  typedef struct packed {
    logic       pause;
    logic       service;
    logic [3:0] coin;
    logic [3:0] start;
    logic [3:0] btn;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
  } kb_t;

  logic tog_q;
  kb_t  kb_q, kb_d;
  logic [7:0] kb_btn8;

  // Raw per-player controls: dir bit order 0 right, 1 left, 2 down, 3 up.
  logic [3:0]         raw_dir   [PLAYERS];
  logic [BUTTONS-1:0] raw_btn   [PLAYERS];
  logic [PLAYERS-1:0] raw_start;
  logic [PLAYERS-1:0] raw_coin;
  logic               raw_pause;

  // SOCD history: previous raw directions and one-hot winner per axis (same bit order).
  logic [3:0] dir_prev_q [PLAYERS];
  logic [3:0] win_q      [PLAYERS];
  logic [3:0] win_d      [PLAYERS];
  logic [3:0] clean_dir  [PLAYERS];

  logic [AW-1:0]      af_cnt_q   [PLAYERS];
  logic [AW-1:0]      af_cnt_d   [PLAYERS];
  logic [PLAYERS-1:0] af_ph_q, af_ph_d;
  logic [CW-1:0]      coin_cnt_q [PLAYERS];
  logic [CW-1:0]      coin_cnt_d [PLAYERS];
  logic [PLAYERS-1:0] coin_prev_q;

  logic [4*PLAYERS-1:0]       dir_n_q, dir_n_d;
  logic [BUTTONS*PLAYERS-1:0] btn_n_q, btn_n_d;
  logic [PLAYERS-1:0]         start_n_q, start_n_d;
  logic [PLAYERS-1:0]         coin_n_q, coin_n_d;
  logic                       service_n_q, service_n_d;
  logic                       pause_q, pause_d;

  // Extended-key flag, spare joystick bits and keys of absent players carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joystick, kb_q, kb_btn8};

  assign kb_btn8 = {4'b0000, kb_q.btn};

  // On a toggle-strobe change, write the pressed flag into the latch selected by the scancode.
  always_comb begin
    kb_d = kb_q;
    if (ps2_key[10] != tog_q) begin
      case (ps2_key[7:0])
        8'h75:   kb_d.up       = ps2_key[9];
        8'h72:   kb_d.down     = ps2_key[9];
        8'h6B:   kb_d.left     = ps2_key[9];
        8'h74:   kb_d.right    = ps2_key[9];
        8'h14:   kb_d.btn[0]   = ps2_key[9];
        8'h11:   kb_d.btn[1]   = ps2_key[9];
        8'h29:   kb_d.btn[2]   = ps2_key[9];
        8'h12:   kb_d.btn[3]   = ps2_key[9];
        8'h16:   kb_d.start[0] = ps2_key[9];
        8'h1E:   kb_d.start[1] = ps2_key[9];
        8'h26:   kb_d.start[2] = ps2_key[9];
        8'h25:   kb_d.start[3] = ps2_key[9];
        8'h2E:   kb_d.coin[0]  = ps2_key[9];
        8'h36:   kb_d.coin[1]  = ps2_key[9];
        8'h3D:   kb_d.coin[2]  = ps2_key[9];
        8'h3E:   kb_d.coin[3]  = ps2_key[9];
        8'h46:   kb_d.service  = ps2_key[9];
        8'h4D:   kb_d.pause    = ps2_key[9];
        default: ;
      endcase
    end
  end

  // Toggle tracker keeps following the strobe during reset so a stale level never writes after it.
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
    if (reset) kb_q <= '0;
    else       kb_q <= kb_d;
  end

  // Merge keyboard latches with joystick bits into per-player raw controls.
  always_comb begin
    raw_pause = kb_q.pause;
    for (int p = 0; p < PLAYERS; p++) begin
      raw_dir[p]   = joystick[16*p +: 4];
      raw_btn[p]   = joystick[16*p+4 +: BUTTONS];
      raw_start[p] = joystick[16*p+4+BUTTONS] | kb_q.start[p];
      raw_coin[p]  = joystick[16*p+5+BUTTONS] | kb_q.coin[p];
      raw_pause    = raw_pause | joystick[16*p+6+BUTTONS];
    end
    raw_dir[0] = raw_dir[0] | {kb_q.up, kb_q.down, kb_q.left, kb_q.right};
    raw_btn[0] = raw_btn[0] | kb_btn8[BUTTONS-1:0];
  end

  // One SOCD axis: returns {next_win_a, next_win_b, out_a, out_b}.
  function automatic logic [3:0] socd_axis(input logic a, input logic b,
                                           input logic pa, input logic pb,
                                           input logic wa, input logic wb,
                                           input logic [1:0] mode);
    logic ra, rb, nwa, nwb, oa, ob;
    ra  = a & ~pa;
    rb  = b & ~pb;
    nwa = wa;
    nwb = wb;
    if (ra && rb) begin
      nwa = 1'b0;
      nwb = 1'b0;
    end else if (ra) begin
      nwa = 1'b1;
      nwb = 1'b0;
    end else if (rb) begin
      nwa = 1'b0;
      nwb = 1'b1;
    end
    oa = a;
    ob = b;
    if (a && b) begin
      case (mode)
        2'd1: begin
          oa = 1'b0;
          ob = 1'b0;
        end
        2'd2: begin
          oa = nwa;
          ob = nwb;
        end
        default: ;
      endcase
    end
    return {nwa, nwb, oa, ob};
  endfunction

  // Clean each axis; winner history is tracked in every mode so switching modes is seamless.
  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      logic [3:0] ax, ay;
      ax = socd_axis(raw_dir[p][0], raw_dir[p][1], dir_prev_q[p][0], dir_prev_q[p][1],
                     win_q[p][0], win_q[p][1], socd_mode);
      ay = socd_axis(raw_dir[p][2], raw_dir[p][3], dir_prev_q[p][2], dir_prev_q[p][3],
                     win_q[p][2], win_q[p][3], socd_mode);
      win_d[p]     = {ay[2], ay[3], ax[2], ax[3]};
      clean_dir[p] = {ay[0], ay[1], ax[0], ax[1]};
    end
  end

  // Autofire and coin counters plus the next registered output values.
  always_comb begin
    dir_n_d     = '1;
    btn_n_d     = '1;
    start_n_d   = '1;
    coin_n_d    = '1;
    af_ph_d     = '0;
    service_n_d = ~kb_q.service;
    pause_d     = raw_pause;
    for (int p = 0; p < PLAYERS; p++) begin
      af_cnt_d[p]   = '0;
      coin_cnt_d[p] = coin_cnt_q[p];
      if (|(raw_btn[p] & af_mask)) begin
        if (af_cnt_q[p] == AW'(AF_HALF - 1)) begin
          af_cnt_d[p] = '0;
          af_ph_d[p]  = ~af_ph_q[p];
        end else begin
          af_cnt_d[p] = af_cnt_q[p] + AW'(1);
          af_ph_d[p]  = af_ph_q[p];
        end
      end
      if (raw_coin[p] && !coin_prev_q[p]) coin_cnt_d[p] = CW'(COIN_MIN);
      else if (coin_cnt_q[p] != '0)      coin_cnt_d[p] = coin_cnt_q[p] - CW'(1);
      // Output order per player is {down, up, right, left}.
      dir_n_d[4*p +: 4] = ~{clean_dir[p][2], clean_dir[p][3], clean_dir[p][0], clean_dir[p][1]};
      // Phase 0 fires, so the first shot lands on the press cycle.
      btn_n_d[BUTTONS*p +: BUTTONS] = ~(raw_btn[p] & ~(af_mask & {BUTTONS{af_ph_q[p]}}));
      start_n_d[p] = ~raw_start[p];
      coin_n_d[p]  = ~(raw_coin[p] | (coin_cnt_d[p] != '0));
    end
  end

  // State and output registers; reset clears all history and parks outputs inactive.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int p = 0; p < PLAYERS; p++) begin
        dir_prev_q[p] <= '0;
        win_q[p]      <= '0;
        af_cnt_q[p]   <= '0;
        coin_cnt_q[p] <= '0;
      end
      af_ph_q     <= '0;
      coin_prev_q <= '0;
      dir_n_q     <= '1;
      btn_n_q     <= '1;
      start_n_q   <= '1;
      coin_n_q    <= '1;
      service_n_q <= 1'b1;
      pause_q     <= 1'b0;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        dir_prev_q[p] <= raw_dir[p];
        win_q[p]      <= win_d[p];
        af_cnt_q[p]   <= af_cnt_d[p];
        coin_cnt_q[p] <= coin_cnt_d[p];
      end
      af_ph_q     <= af_ph_d;
      coin_prev_q <= raw_coin;
      dir_n_q     <= dir_n_d;
      btn_n_q     <= btn_n_d;
      start_n_q   <= start_n_d;
      coin_n_q    <= coin_n_d;
      service_n_q <= service_n_d;
      pause_q     <= pause_d;
    end
  end

  assign dir_n     = dir_n_q;
  assign btn_n     = btn_n_q;
  assign start_n   = start_n_q;
  assign coin_n    = coin_n_q;
  assign service_n = service_n_q;
  assign pause_btn = pause_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed checks of keyboard latching, SOCD, autofire, coin stretch and reset.
// Three instances: 2 players (main), 1 player and 4 players for the player-count bounds.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_arcade_input_mapper;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joy;
  logic [15:0] joy1;
  logic [63:0] joy4;
  logic [1:0]  socd_mode;
  logic [3:0]  af_mask;

  logic [7:0]  dir_n, btn_n;
  logic [1:0]  start_n, coin_n;
  logic        service_n, pause_btn;
  logic [3:0]  dir1_n, btn1_n;
  logic        start1_n, coin1_n, service1_n, pause1;
  logic [15:0] dir4_n, btn4_n;
  logic [3:0]  start4_n, coin4_n;
  logic        service4_n, pause4;

  int passed = 0;
  int total  = 0;

  arcade_input_mapper #(.PLAYERS(2), .BUTTONS(4), .COIN_MIN(8), .AF_HALF(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joystick(joy),
    .socd_mode(socd_mode), .af_mask(af_mask), .dir_n(dir_n), .btn_n(btn_n),
    .start_n(start_n), .coin_n(coin_n), .service_n(service_n), .pause_btn(pause_btn));

  arcade_input_mapper #(.PLAYERS(1), .BUTTONS(4), .COIN_MIN(8), .AF_HALF(4)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joystick(joy1),
    .socd_mode(socd_mode), .af_mask(af_mask), .dir_n(dir1_n), .btn_n(btn1_n),
    .start_n(start1_n), .coin_n(coin1_n), .service_n(service1_n), .pause_btn(pause1));

  arcade_input_mapper #(.PLAYERS(4), .BUTTONS(4), .COIN_MIN(8), .AF_HALF(4)) dut4 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joystick(joy4),
    .socd_mode(socd_mode), .af_mask(af_mask), .dir_n(dir4_n), .btn_n(btn4_n),
    .start_n(start4_n), .coin_n(coin4_n), .service_n(service4_n), .pause_btn(pause4));

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic press(input logic dn, input logic [7:0] code);
    ps2_key = {~ps2_key[10], dn, 1'b0, code};
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; ps2_key = '0; joy = '0; joy1 = '0; joy4 = '0;
    socd_mode = 2'd0; af_mask = 4'b0000;
    tick(); tick();
    check("rst_dir", dir_n, 8'hFF);
    check("rst_btn", btn_n, 8'hFF);
    check("rst_start", start_n, 2'b11);
    check("rst_coin", coin_n, 2'b11);
    check("rst_service", service_n, 1'b1);
    check("rst_pause", pause_btn, 1'b0);
    reset = 1'b0;
    tick();

    // Keyboard P1 up: latch on first edge, output on the second.
    press(1'b1, 8'h75); tick();
    check("kb_up_early", dir_n[3:0], 4'hF);
    tick();
    check("kb_up_on", dir_n[3:0], 4'b1011);
    press(1'b0, 8'h75); tick();
    check("kb_up_hold", dir_n[3:0], 4'b1011);
    tick();
    check("kb_up_off", dir_n[3:0], 4'hF);

    // Service and pause keys, then joystick pause bit of P2.
    press(1'b1, 8'h46); tick();
    press(1'b1, 8'h4D); tick();
    check("kb_service", service_n, 1'b0);
    tick();
    check("kb_pause", pause_btn, 1'b1);
    press(1'b0, 8'h46); tick();
    press(1'b0, 8'h4D); tick(); tick();
    check("kb_service_off", service_n, 1'b1);
    check("kb_pause_off", pause_btn, 1'b0);
    joy[26] = 1'b1; tick();
    check("joy_pause", pause_btn, 1'b1);
    joy[26] = 1'b0;

    // Joystick P2 button 0 and start: one-cycle latency.
    joy[20] = 1'b1; joy[24] = 1'b1; tick();
    check("joy_p2_btn", btn_n, 8'hEF);
    check("joy_p2_start", start_n, 2'b01);
    joy = '0; tick();
    check("joy_p2_rel", {btn_n, start_n}, {8'hFF, 2'b11});

    // Keyboard right and joystick left in the same cycle.
    press(1'b1, 8'h74); joy[1] = 1'b1; tick();
    check("same_cyc_joy", dir_n[1:0], 2'b10);
    tick();
    check("same_cyc_both", dir_n[1:0], 2'b00);
    press(1'b0, 8'h74); joy = '0; tick(); tick();
    check("same_cyc_rel", dir_n[3:0], 4'hF);

    // SOCD modes on P1 left/right.
    joy[1:0] = 2'b11; tick();
    check("socd0_both", dir_n[1:0], 2'b00);
    socd_mode = 2'd1; tick();
    check("socd1_both", dir_n[1:0], 2'b11);
    socd_mode = 2'd3; tick();
    check("socd3_both", dir_n[1:0], 2'b00);
    joy = '0; socd_mode = 2'd2; tick();
    joy[1] = 1'b1; tick();
    check("socd2_left", dir_n[1:0], 2'b10);
    joy[0] = 1'b1; tick();
    check("socd2_right_wins", dir_n[1:0], 2'b01);
    joy[0] = 1'b0; tick();
    check("socd2_left_back", dir_n[1:0], 2'b10);
    joy = '0; tick();
    // Up and down rising together: neutral until one releases.
    joy[3:2] = 2'b11; tick();
    check("socd2_tie", dir_n[3:2], 2'b11);
    tick();
    check("socd2_tie_hold", dir_n[3:2], 2'b11);
    joy[3] = 1'b0; tick();
    check("socd2_down", dir_n[3:2], 2'b01);
    socd_mode = 2'd1; tick();
    check("socd1_single", dir_n[3:2], 2'b01);
    joy = '0; socd_mode = 2'd0; tick();

    // Coin stretch on P2: single pulse gives exactly 8 low cycles.
    for (int i = 0; i < 12; i++) begin
      joy[25] = (i == 0);
      tick();
      check("coin_single", coin_n[1], (i < 8) ? 1'b0 : 1'b1);
    end
    // Second pulse five cycles in reloads the counter.
    for (int i = 0; i < 16; i++) begin
      joy[25] = (i == 0) || (i == 5);
      tick();
      check("coin_reload", coin_n[1], (i <= 12) ? 1'b0 : 1'b1);
    end
    joy = '0;

    // Autofire on P1 button 0: four on, four off.
    af_mask = 4'b0001; joy[4] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("af_pattern", btn_n[0], ((i / 4) % 2) == 1);
    end
    joy[4] = 1'b0; tick();
    check("af_release", btn_n[0], 1'b1);
    joy[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("af_unmasked", btn_n[1], 1'b0);
    end
    joy[5] = 1'b0; tick();

    // Reset mid-stretch and mid-autofire (phase 1 at reset time).
    joy[25] = 1'b1; joy[4] = 1'b1;
    repeat (6) tick();
    reset = 1'b1; tick();
    check("rst_mid_dir", dir_n, 8'hFF);
    check("rst_mid_btn", btn_n, 8'hFF);
    check("rst_mid_coin", coin_n, 2'b11);
    check("rst_mid_misc", {start_n, service_n, pause_btn}, 4'b1110);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) joy[25] = 1'b0;
      tick();
      check("rst_coin_retrig", coin_n[1], (i < 8) ? 1'b0 : 1'b1);
      check("rst_af_restart", btn_n[0], ((i / 4) % 2) == 1);
    end
    joy = '0; af_mask = 4'b0000; tick();

    // Player-count bounds: P2 start key ignored with one player.
    press(1'b1, 8'h1E); tick(); tick();
    check("p1_only_start2", start1_n, 1'b1);
    check("p1_only_rest", {dir1_n, btn1_n, coin1_n, service1_n, pause1}, {4'hF, 4'hF, 1'b1, 1'b1, 1'b0});
    check("p2_kb_start2", start_n, 2'b01);
    check("p4_kb_start2", start4_n, 4'b1101);
    joy4[56] = 1'b1; tick();
    check("p4_joy_start4", start4_n, 4'b0101);
    press(1'b1, 8'h16); tick(); tick();
    check("p1_only_start1", start1_n, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised player-input front end for arcade cores: merges the PS/2 keyboard and up to four MiSTer joysticks into active-low cabinet signals, with optional SOCD cleaning, per-button autofire, and coin pulse stretching. Sits in `emu` between `hps_io` (`ps2_key`, `joystick_N`) and the game top-level. It replaces the hand-written keyboard `always` block and the `m_*` wire mapping in each core.

## Interface
- `PLAYERS`, default 2: number of players, 1..4.
- `BUTTONS`, default 4: action buttons per player, 1..8.
- `COIN_MIN`, default 2450000: minimum coin assertion in clocks (50 ms at 49 MHz), ≥1.
- `AF_HALF`, default 1633333: autofire half-period in clocks, ≥1.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `ps2_key`  in  11  `hps_io` key word: [10] toggle strobe, [9] pressed, [8] extended (ignored), [7:0] scancode.
- `joystick`  in  16*PLAYERS  player p at [16p+15:16p]. Bits 0 right, 1 left, 2 down, 3 up, 4..3+BUTTONS buttons, 4+BUTTONS start, 5+BUTTONS coin.
- `socd_mode`  in  2  0 pass-through, 1 neutral, 2 last-input-wins, 3 treated as 0.
- `af_mask`  in  BUTTONS  bit b set: button b autofires for all players.
- `dir_n`  out  4*PLAYERS  per player {down,up,right,left}, active-low.
- `btn_n`  out  BUTTONS*PLAYERS  player p at [BUTTONS*p +: BUTTONS], active-low.
- `start_n`  out  PLAYERS  active-low.
- `coin_n`  out  PLAYERS  active-low, stretched.
- `service_n`  out  1  active-low.
- `pause_btn`  out  1  active-high level, feeds `pause.user_button`.

## Operation
- Keyboard latch: register `ps2_key[10]` each cycle. On a change, write `ps2_key[9]` into the latch for the decoded scancode. Unknown codes are ignored.
- Key map:
  - 0x75/0x72/0x6B/0x74: P1 up/down/left/right.
  - 0x14/0x11/0x29/0x12: P1 button 0/1/2/3; only buttons < BUTTONS are used.
  - 0x16/0x1E/0x26/0x25: start P1..P4.
  - 0x2E/0x36/0x3D/0x3E: coin P1..P4.
  - 0x46: service. 0x4D: pause.
  - Keys for players ≥ PLAYERS are ignored.
- Raw per player = keyboard latch OR joystick bits. The keyboard drives directions and buttons for P1 only.
- `pause_btn` = pause key OR bit 6+BUTTONS of any joystick.
- SOCD, applied per player per axis (left/right, up/down):
  - Mode 1: both raw set → both outputs inactive.
  - Mode 2: track the direction with the most recent rising edge; both raw set → only that direction active. If both rise in the same cycle, both are inactive until one releases.
  - Single direction held: passes through in every mode.
- Autofire, one counter per player:
  - The counter runs while any masked button of that player is held. It clears to 0 when none is held.
  - Phase flips every AF_HALF clocks. A masked button's output is active only in phase 0, so the first shot is immediate.
  - Unmasked buttons pass through.
- Coin stretch, per player:
  - A rising edge of raw coin loads a down-counter with COIN_MIN.
  - `coin_n` is low while raw coin is high or the counter is nonzero.
  - A new rising edge during countdown reloads the counter.
- Start and service pass through with no processing.

## Timing
- All outputs are registered.
- Joystick change → output change 1 cycle later.
- `ps2_key` toggle → keyboard latch update +1 cycle → output +2 cycles.
- Reset values:
  - Keyboard latches, SOCD history, autofire counters/phase, coin counters: 0.
  - All `_n` outputs: 1. `pause_btn`: 0.
- `reset` asserted mid-stretch or mid-autofire: counters clear. Outputs return inactive on the cycle after reset is sampled.
- Counter widths: $clog2(COIN_MIN+1) and $clog2(AF_HALF). There is no overflow; the autofire counter wraps to 0 at AF_HALF-1 and flips phase.
- Keyboard toggle and a joystick change in the same cycle: both take effect; no ordering dependency.

## Test plan
- PS2 press: toggle `ps2_key` with {pressed=1, code=0x75} → `dir_n[2]` (P1 up) = 0 two cycles later. Same toggle with pressed=0 → returns to 1.
- SOCD: `socd_mode`=1, joystick0 bits 0,1 both set → `dir_n[1:0]`=2'b11. `socd_mode`=2, left then right one cycle later → right active, left inactive. Release right → left active.
- Coin stretch (COIN_MIN=8): a 1-cycle `joystick` coin pulse for P2 → `coin_n[1]` low for exactly 8 cycles. A second pulse at cycle 5 → low until cycle 13.
- Autofire (AF_HALF=4, `af_mask`=4'b0001): hold P1 button 0 → `btn_n[0]` pattern 0000 1111 0000… starting 1 cycle after press. Release → 1 next cycle. Button 1 held → steady 0.
- Reset mid-operation: assert `reset` during a coin stretch and autofire → all outputs inactive on the next cycle. After deassert, the held coin re-triggers a full COIN_MIN stretch.
- Bounds: PLAYERS=1, scancode 0x1E pressed → no output change. PLAYERS=4 joystick3 start → `start_n[3]`=0.
